// File: rtl/delta_sigma_1bit_adc_pkg.sv
// Shared definitions for the 1-bit delta-sigma ADC: warm-up states, CIC sizing and PCM helpers.
package delta_sigma_1bit_adc_pkg;

    typedef enum logic [1:0] {
        WARM_0   = 2'd0,
        WARM_1   = 2'd1,
        WARM_RUN = 2'd2
    } warm_e;

    function automatic int unsigned log2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Second-order CIC needs 2*log2(R) bits of growth plus one for the full-scale value R^2.
    function automatic int unsigned cic_w_f(input int unsigned dec_log2);
        return 2 * dec_log2 + 1;
    endfunction

    function automatic int unsigned midscale_f(input int unsigned dat_w);
        return 32'd1 << (dat_w - 1);
    endfunction

endpackage

// File: rtl/delta_sigma_1bit_adc_cic2_decim.sv
// Second-order CIC decimator with warm-up suppression and full-scale clip.
// Macro DSADC_OVR_EN exposes the comb result and valid-event strobe for the overload flag.
module delta_sigma_1bit_adc_cic2_decim
    import delta_sigma_1bit_adc_pkg::*;
#(
    parameter int unsigned C_DAT_W    = 12,
    parameter int unsigned C_DEC_LOG2 = 8
) (
    input  logic                  CK_i,
    input  logic                  XARST_i,
    input  logic                  EN_CK_i,
    input  logic                  Q_i,
`ifdef DSADC_OVR_EN
    output logic [2*C_DEC_LOG2:0] Y_c_o,
    output logic                  VLD_EVT_c_o,
`endif
    output logic [C_DAT_W-1:0]    DAT_o,
    output logic                  DAT_VLD_o
);

    localparam int unsigned CIC_W = cic_w_f(C_DEC_LOG2);
    localparam int unsigned SHIFT = 2 * C_DEC_LOG2 - C_DAT_W;
    localparam logic [CIC_W-1:0] Y_FS = CIC_W'(1) << (2 * C_DEC_LOG2);
    localparam logic [C_DEC_LOG2-1:0] CTR_LAST = '1;

    logic [CIC_W-1:0]      i1_q, i2_q, i2_dly_q, c1_dly_q;
    logic [CIC_W-1:0]      c1_c, y_c, ys_c;
    logic [C_DEC_LOG2-1:0] ctr_q;
    warm_e                 warm_q, warm_d;
    logic [C_DAT_W-1:0]    dat_q, dat_d;
    logic                  vld_q, vld_d;
    logic                  evt_c;

    // Combs run once per decimation event; modulo arithmetic keeps them exact.
    assign evt_c = EN_CK_i && (ctr_q == CTR_LAST);
    assign c1_c  = i2_q - i2_dly_q;
    assign y_c   = c1_c - c1_dly_q;
    assign ys_c  = (y_c == Y_FS) ? (Y_FS - CIC_W'(1)) : y_c;

    // Warm-up sequencer: the first two events only prime the comb delays.
    always_comb begin
        warm_d = warm_q;
        dat_d  = dat_q;
        vld_d  = 1'b0;
        if (evt_c) begin
            case (warm_q)
                WARM_0:  warm_d = WARM_1;
                WARM_1:  warm_d = WARM_RUN;
                default: begin
                    vld_d = 1'b1;
                    dat_d = C_DAT_W'(ys_c >> SHIFT);
                end
            endcase
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            warm_q   <= WARM_0;
            dat_q    <= '0;
            vld_q    <= 1'b0;
            i1_q     <= '0;
            i2_q     <= '0;
            i2_dly_q <= '0;
            c1_dly_q <= '0;
            ctr_q    <= '0;
        end else begin
            warm_q <= warm_d;
            dat_q  <= dat_d;
            vld_q  <= vld_d;
            if (EN_CK_i) begin
                i1_q  <= i1_q + CIC_W'(Q_i);
                i2_q  <= i2_q + i1_q;
                ctr_q <= ctr_q + C_DEC_LOG2'(1);
                if (evt_c) begin
                    i2_dly_q <= i2_q;
                    c1_dly_q <= c1_c;
                end
            end
        end
    end

    assign DAT_o     = dat_q;
    assign DAT_VLD_o = vld_q;
`ifdef DSADC_OVR_EN
    assign Y_c_o       = y_c;
    assign VLD_EVT_c_o = vld_d;
`endif

endmodule

// File: rtl/delta_sigma_1bit_adc.sv
// First-order delta-sigma ADC loop: comparator sync, feedback drive and CIC decimation to PCM.
// Macro DSADC_OVR_EN adds the OVR_o overload flag.
module delta_sigma_1bit_adc
    import delta_sigma_1bit_adc_pkg::*;
#(
    parameter int unsigned C_DAT_W    = 12,
    parameter int unsigned C_DEC_LOG2 = 8
) (
    input  logic               CK_i,
    input  logic               XARST_i,
    input  logic               EN_CK_i,
    input  logic               CMP_i,
    output logic               FB_P_o,
    output logic               FB_N_o,
    output logic [C_DAT_W-1:0] DAT_o,
`ifdef DSADC_OVR_EN
    output logic               OVR_o,
`endif
    output logic               DAT_VLD_o
);

    logic sync1_q, sync2_q;
    logic q_q, fb_n_q;

    // Comparator synchroniser runs every clock regardless of the enable.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= CMP_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            q_q    <= 1'b0;
            fb_n_q <= 1'b1;
        end else if (EN_CK_i) begin
            q_q    <= sync2_q;
            fb_n_q <= ~sync2_q;
        end
    end

    assign FB_P_o = q_q;
    assign FB_N_o = fb_n_q;

`ifdef DSADC_OVR_EN
    localparam int unsigned CIC_W = cic_w_f(C_DEC_LOG2);
    localparam logic [CIC_W-1:0] Y_FS = CIC_W'(1) << (2 * C_DEC_LOG2);

    logic [CIC_W-1:0] y_c;
    logic             vld_evt_c;
    logic             ovr_q;

    // Flag either rail hit; held until the next valid output sample.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            ovr_q <= 1'b0;
        end else if (vld_evt_c) begin
            ovr_q <= (y_c == Y_FS) || (y_c == '0);
        end
    end

    assign OVR_o = ovr_q;
`endif

    delta_sigma_1bit_adc_cic2_decim #(
        .C_DAT_W    (C_DAT_W),
        .C_DEC_LOG2 (C_DEC_LOG2)
    ) u_cic2_decim (
        .CK_i        (CK_i),
        .XARST_i     (XARST_i),
        .EN_CK_i     (EN_CK_i),
        .Q_i         (q_q),
`ifdef DSADC_OVR_EN
        .Y_c_o       (y_c),
        .VLD_EVT_c_o (vld_evt_c),
`endif
        .DAT_o       (DAT_o),
        .DAT_VLD_o   (DAT_VLD_o)
    );

endmodule

// File: tb/tb_delta_sigma_1bit_adc.sv
// Self-checking bench for delta_sigma_1bit_adc: scoreboard of expected PCM strobes per stimulus pattern.
module tb_delta_sigma_1bit_adc;

    localparam int DAT_W = 12;
    localparam int R     = 256;

    logic             ck, xarst, en_ck, cmp;
    logic             fb_p, fb_n, dat_vld;
    logic [DAT_W-1:0] dat;
`ifdef DSADC_OVR_EN
    logic             ovr;
`endif

    typedef struct {
        logic [DAT_W-1:0] dat;
        logic             ovr;
        int               at_en;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [3:0] pat_bits;
    int   pat_len, en_div, cyc, en_cnt;
    logic prev_en;

    delta_sigma_1bit_adc #(.C_DAT_W(12), .C_DEC_LOG2(8)) dut (
        .CK_i      (ck),
        .XARST_i   (xarst),
        .EN_CK_i   (en_ck),
        .CMP_i     (cmp),
        .FB_P_o    (fb_p),
        .FB_N_o    (fb_n),
        .DAT_o     (dat),
`ifdef DSADC_OVR_EN
        .OVR_o     (ovr),
`endif
        .DAT_VLD_o (dat_vld)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic drive_inputs();
        en_ck = ((cyc % en_div) == 0);
        cmp   = pat_bits[(cyc / en_div) % pat_len];
    endtask

    // One clock: count enabled edges out of reset, then drive next inputs on the falling edge.
    task automatic tick();
        @(posedge ck);
        if (xarst && en_ck) en_cnt++;
        prev_en = en_ck;
        @(negedge ck);
        cyc++;
        drive_inputs();
    endtask

    task automatic do_reset();
        xarst = 1'b0;
        cyc   = 0;
        drive_inputs();
        repeat (2) @(negedge ck);
        sb_q.delete();
        en_cnt  = 0;
        prev_en = 1'b0;
        xarst   = 1'b1;
    endtask

    task automatic push_exp(input logic [DAT_W-1:0] d, input logic o, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.dat   = d;
            e.ovr   = o;
            e.at_en = 3 * R + R * i;
            sb_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        pat_bits = 4'b0001; pat_len = 1; en_div = 1; cyc = 0;
        drive_inputs();
        xarst = 1'b1;
        #1 xarst = 1'b0;
        #10;
        n_checks++;
        if ({fb_p, fb_n, dat_vld, dat} !== {1'b0, 1'b1, 1'b0, 12'h000})
            $display("FAIL reset_outputs got fb_p=%b fb_n=%b vld=%b dat=%h want 0 1 0 000", fb_p, fb_n, dat_vld, dat);
        else n_pass++;
`ifdef DSADC_OVR_EN
        n_checks++;
        if (ovr !== 1'b0) $display("FAIL reset_ovr got %b want 0", ovr);
        else n_pass++;
`endif
    endtask

    task automatic test_feedback_latency();
        pat_bits = 4'b0001; pat_len = 1; en_div = 1;
        do_reset();
        tick(); tick();
        n_checks++;
        if (fb_p !== 1'b0) $display("FAIL fb_latency_2ck got %b want 0", fb_p);
        else n_pass++;
        tick();
        n_checks++;
        if ({fb_p, fb_n} !== 2'b10) $display("FAIL fb_latency_3ck got %b%b want 10", fb_p, fb_n);
        else n_pass++;
    endtask

    task automatic test_pattern(input string name, input logic [3:0] bits, input int len,
                                input logic [DAT_W-1:0] exp_dat, input logic exp_ovr, input int n);
        exp_t e;
        pat_bits = bits; pat_len = len; en_div = 1;
        do_reset();
        push_exp(exp_dat, exp_ovr, n);
        for (int c = 0; c < 3 * R + R * n + 64 && sb_q.size() > 0; c++) begin
            tick();
            if (dat_vld) begin
                e = sb_q.pop_front();
                n_checks++;
                if (dat !== e.dat) $display("FAIL %s dat got %h want %h", name, dat, e.dat);
                else n_pass++;
                n_checks++;
                if (en_cnt !== e.at_en) $display("FAIL %s strobe_at_en got %0d want %0d", name, en_cnt, e.at_en);
                else n_pass++;
`ifdef DSADC_OVR_EN
                n_checks++;
                if (ovr !== e.ovr) $display("FAIL %s ovr got %b want %b", name, ovr, e.ovr);
                else n_pass++;
`endif
            end
        end
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL %s timeout pending got %0d want 0", name, sb_q.size());
        else n_pass++;
        if (len == 1) begin
            n_checks++;
            if ({fb_p, fb_n} !== {bits[0], ~bits[0]})
                $display("FAIL %s feedback got %b%b want %b%b", name, fb_p, fb_n, bits[0], ~bits[0]);
            else n_pass++;
        end
    endtask

    task automatic test_sparse_enable();
        exp_t e;
        int last_cyc, frozen_viol, width_viol, n_seen;
        logic last_fb, last_vld;
        logic [DAT_W-1:0] last_dat;
        pat_bits = 4'b0101; pat_len = 2; en_div = 4;
        do_reset();
        push_exp(12'h800, 1'b0, 3);
        frozen_viol = 0; width_viol = 0; n_seen = 0; last_cyc = 0;
        last_fb = fb_p; last_dat = dat; last_vld = dat_vld;
        for (int c = 0; c < 4 * 6 * R + 64 && sb_q.size() > 0; c++) begin
            tick();
            if (!prev_en && (fb_p !== last_fb || dat !== last_dat)) frozen_viol++;
            if (dat_vld && last_vld) width_viol++;
            if (dat_vld) begin
                e = sb_q.pop_front();
                n_checks++;
                if (dat !== e.dat) $display("FAIL sparse dat got %h want %h", dat, e.dat);
                else n_pass++;
                n_checks++;
                if (en_cnt !== e.at_en) $display("FAIL sparse strobe_at_en got %0d want %0d", en_cnt, e.at_en);
                else n_pass++;
                if (n_seen > 0) begin
                    n_checks++;
                    if (cyc - last_cyc !== 4 * R) $display("FAIL sparse period got %0d want %0d", cyc - last_cyc, 4 * R);
                    else n_pass++;
                end
                last_cyc = cyc;
                n_seen++;
            end
            last_fb = fb_p; last_dat = dat; last_vld = dat_vld;
        end
        tick();
        if (dat_vld && last_vld) width_viol++;
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sparse timeout pending got %0d want 0", sb_q.size());
        else n_pass++;
        n_checks++;
        if (width_viol !== 0) $display("FAIL sparse vld_width got %0d wide strobes want 0", width_viol);
        else n_pass++;
        n_checks++;
        if (frozen_viol !== 0) $display("FAIL sparse frozen got %0d changes want 0", frozen_viol);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        exp_t e;
        pat_bits = 4'b0101; pat_len = 2; en_div = 1;
        do_reset();
        push_exp(12'h800, 1'b0, 1);
        for (int c = 0; c < 1200 && en_cnt < 3 * R + 100; c++) begin
            tick();
            if (dat_vld) begin
                e = sb_q.pop_front();
                n_checks++;
                if (dat !== e.dat) $display("FAIL midop_pre dat got %h want %h", dat, e.dat);
                else n_pass++;
            end
        end
        n_checks++;
        if (en_cnt !== 3 * R + 100 || sb_q.size() != 0)
            $display("FAIL midop_reach got en=%0d pending=%0d want %0d 0", en_cnt, sb_q.size(), 3 * R + 100);
        else n_pass++;
        xarst = 1'b0;
        #1;
        n_checks++;
        if ({fb_p, fb_n, dat_vld, dat} !== {1'b0, 1'b1, 1'b0, 12'h000})
            $display("FAIL midop_reset got fb_p=%b fb_n=%b vld=%b dat=%h want 0 1 0 000", fb_p, fb_n, dat_vld, dat);
        else n_pass++;
        repeat (2) @(negedge ck);
        en_cnt = 0;
        sb_q.delete();
        xarst = 1'b1;
        push_exp(12'h800, 1'b0, 1);
        for (int c = 0; c < 3 * R + 64 && sb_q.size() > 0; c++) begin
            tick();
            if (dat_vld) begin
                e = sb_q.pop_front();
                n_checks++;
                if (en_cnt !== e.at_en) $display("FAIL midop_restart got en=%0d want %0d", en_cnt, e.at_en);
                else n_pass++;
                n_checks++;
                if (dat !== e.dat) $display("FAIL midop_post dat got %h want %h", dat, e.dat);
                else n_pass++;
            end
        end
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL midop timeout pending got %0d want 0", sb_q.size());
        else n_pass++;
    endtask

    initial begin
        xarst = 1'b1; en_ck = 1'b1; cmp = 1'b0;
        pat_bits = 4'b0000; pat_len = 1; en_div = 1; cyc = 0; en_cnt = 0; prev_en = 1'b0;
        test_reset();
        test_feedback_latency();
        test_pattern("held_one",  4'b0001, 1, 12'hFFF, 1'b1, 3);
        test_pattern("held_zero", 4'b0000, 1, 12'h000, 1'b1, 3);
        test_pattern("toggle",    4'b0101, 2, 12'h800, 1'b0, 3);
        test_pattern("quarter",   4'b0001, 4, 12'h400, 1'b0, 2);
        test_pattern("three_q",   4'b0111, 4, 12'hC00, 1'b0, 2);
        test_sparse_enable();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
